// File: rtl/ddr3_int_ex_pattern_seq.sv
// ---------------------------------------------------------------------------
// ddr3_int_ex_pattern_seq
//
// Sequences a bank of LANES external 8-bit LFSR pattern generators for the
// DDR3 example driver. A run is one write pass that streams LFSR data, a
// reseed, and one read pass that compares the returned data against the
// regenerated LFSR stream. This block owns every LFSR control input.
//
// Optional feature macro: DDR3_PATSEQ_ERR_CAPTURE_EN
//   defined     -> first mismatch of a run (beat index, expected and actual
//                  data) is captured on the first_err_* outputs.
//   not defined -> first_err_* outputs exist but are tied to zero.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start               pulse, accepted only in IDLE or DONE
//   seed, num_beats     run configuration, sampled on an accepted start
//   lfsr_enable/pause/load, lfsr_ldata   control of all LFSR lanes
//   lfsr_data           current LFSR outputs, one byte per lane
//   wr_valid/wr_ready/wr_data            write beat stream
//   rd_valid/rd_data                     returned read beats (no backpressure)
//   busy, done, pass, err_count          run status
//   first_err_beat/exp/act/vld           first-mismatch capture
// ---------------------------------------------------------------------------
module ddr3_int_ex_pattern_seq #(
    parameter int         LANES     = 4,
    parameter int         CNT_W     = 12,
    parameter logic [7:0] SEED_STEP = 8'h11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           seed,
    input  logic [CNT_W-1:0]     num_beats,
    output logic                 lfsr_enable,
    output logic                 lfsr_pause,
    output logic                 lfsr_load,
    output logic [LANES*8-1:0]   lfsr_ldata,
    input  logic [LANES*8-1:0]   lfsr_data,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [LANES*8-1:0]   wr_data,
    input  logic                 rd_valid,
    input  logic [LANES*8-1:0]   rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [CNT_W-1:0]     first_err_beat,
    output logic [LANES*8-1:0]   first_err_exp,
    output logic [LANES*8-1:0]   first_err_act,
    output logic                 first_err_vld
);

    localparam int               LW       = LANES * 8;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RESEED = 3'd3,
        ST_READ   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Seed for one lane: base plus lane index times the per-lane step, mod 256.
    function automatic logic [7:0] lane_seed(input logic [7:0] base, input logic [7:0] idx);
        logic [7:0] offs;
        offs = idx * SEED_STEP;
        return base + offs;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = val;
        end else begin
            res = val + 16'h0001;
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         seed_r;
    logic [CNT_W-1:0]   beats_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [15:0]        err_r;
    logic [15:0]        err_next_s;
    logic               done_r;
    logic               pass_r;

    logic               start_ok_s;
    logic               beats_zero_s;
    logic               last_s;
    logic               wr_fire_s;
    logic               rd_fire_s;
    logic               mismatch_s;
    logic               enable_s;
    logic               pause_s;
    logic               load_s;
    logic               wr_valid_s;
    logic               busy_s;

    assign start_ok_s   = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign beats_zero_s = (num_beats == CNT_ZERO);
    // beats_r is non-zero whenever a pass is running, so the subtraction cannot wrap there.
    assign last_s       = (cnt_r == (beats_r - CNT_ONE));
    assign wr_fire_s    = (state_r == ST_WRITE) & wr_ready;
    assign rd_fire_s    = (state_r == ST_READ) & rd_valid;
    assign mismatch_s   = rd_fire_s & (rd_data != lfsr_data);

    // Saturating error count including the beat compared this cycle.
    always_comb begin
        err_next_s = err_r;
        if (mismatch_s) begin
            err_next_s = sat_inc16(err_r);
        end else begin
            err_next_s = err_r;
        end
    end

    // Next-state and state-decoded LFSR / stream controls.
    always_comb begin
        state_s    = state_r;
        enable_s   = 1'b0;
        pause_s    = 1'b1;
        load_s     = 1'b0;
        wr_valid_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    if (beats_zero_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SEED;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_SEED: begin
                enable_s = 1'b1;
                load_s   = 1'b1;
                busy_s   = 1'b1;
                state_s  = ST_WRITE;
            end
            ST_WRITE: begin
                enable_s   = 1'b1;
                busy_s     = 1'b1;
                wr_valid_s = 1'b1;
                // LFSRs step only on an accepted beat so stalled data is held.
                pause_s    = ~wr_ready;
                if (wr_ready && last_s) begin
                    state_s = ST_RESEED;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_RESEED: begin
                enable_s = 1'b1;
                load_s   = 1'b1;
                busy_s   = 1'b1;
                state_s  = ST_READ;
            end
            ST_READ: begin
                enable_s = 1'b1;
                busy_s   = 1'b1;
                pause_s  = ~rd_valid;
                if (rd_valid && last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, run configuration, beat counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            seed_r  <= 8'h00;
            beats_r <= CNT_ZERO;
            cnt_r   <= CNT_ZERO;
            err_r   <= 16'h0000;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_ok_s) begin
                seed_r  <= seed;
                beats_r <= num_beats;
                cnt_r   <= CNT_ZERO;
                err_r   <= 16'h0000;
                // A zero-length run completes immediately with a clean result.
                done_r  <= beats_zero_s;
                pass_r  <= beats_zero_s;
            end else begin
                err_r <= err_next_s;
                if (wr_fire_s || rd_fire_s) begin
                    // Counter returns to zero after the last write beat, ready for the read pass.
                    cnt_r <= last_s ? CNT_ZERO : (cnt_r + CNT_ONE);
                end
                if (rd_fire_s && last_s) begin
                    done_r <= 1'b1;
                    pass_r <= (err_next_s == 16'h0000);
                end
            end
        end
    end

    // Per-lane reload values derived from the latched base seed.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lfsr_ldata[i*8 +: 8] = lane_seed(seed_r, 8'(i));
    end

    assign lfsr_enable = enable_s;
    assign lfsr_pause  = pause_s;
    assign lfsr_load   = load_s;
    assign wr_valid    = wr_valid_s;
    assign wr_data     = lfsr_data;
    assign busy        = busy_s;
    assign done        = done_r;
    assign pass        = pass_r;
    assign err_count   = err_r;

`ifdef DDR3_PATSEQ_ERR_CAPTURE_EN
    logic               cap_vld_r;
    logic [CNT_W-1:0]   cap_beat_r;
    logic [LW-1:0]      cap_exp_r;
    logic [LW-1:0]      cap_act_r;

    // First-mismatch capture; armed again by every accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_vld_r  <= 1'b0;
            cap_beat_r <= CNT_ZERO;
            cap_exp_r  <= {LW{1'b0}};
            cap_act_r  <= {LW{1'b0}};
        end else if (start_ok_s) begin
            cap_vld_r  <= 1'b0;
            cap_beat_r <= CNT_ZERO;
            cap_exp_r  <= {LW{1'b0}};
            cap_act_r  <= {LW{1'b0}};
        end else if (mismatch_s && !cap_vld_r) begin
            cap_vld_r  <= 1'b1;
            cap_beat_r <= cnt_r;
            cap_exp_r  <= lfsr_data;
            cap_act_r  <= rd_data;
        end else begin
            cap_vld_r  <= cap_vld_r;
        end
    end

    assign first_err_vld  = cap_vld_r;
    assign first_err_beat = cap_beat_r;
    assign first_err_exp  = cap_exp_r;
    assign first_err_act  = cap_act_r;
`else
    assign first_err_vld  = 1'b0;
    assign first_err_beat = CNT_ZERO;
    assign first_err_exp  = {LW{1'b0}};
    assign first_err_act  = {LW{1'b0}};
`endif

endmodule
